// File: rtl/mdiv_pkg.sv
// mdiv_pkg: widths and unloader state encoding shared by the modular-divide
// operand loader and result unloader.
package mdiv_pkg;
    localparam int MDIV_DW    = 256;
    localparam int MDIV_WW    = 32;
    localparam int MDIV_BEATS = MDIV_DW / MDIV_WW;
    typedef enum logic {ST_IDLE, ST_SEND} mdiv_unld_st_e;
endpackage

// File: rtl/mdiv_result_unloader_if.sv
// mdiv_result_unloader_if: capture port plus valid/ready result stream of the unloader.
interface mdiv_result_unloader_if
    import mdiv_pkg::*;
#(
    parameter int DW = MDIV_DW,
    parameter int WW = MDIV_WW
);
    logic          load;
    logic          bit_mode;
    logic [DW-1:0] din;
    logic          load_rdy;
    logic          flush;
    logic          dout_valid;
    logic          dout_ready;
    logic [WW-1:0] dout;
    logic          dout_last;
    modport master (
        output load, bit_mode, din, flush, dout_ready,
        input  load_rdy, dout_valid, dout, dout_last
    );
    modport slave (
        input  load, bit_mode, din, flush, dout_ready,
        output load_rdy, dout_valid, dout, dout_last
    );
endinterface

// File: rtl/mdiv_pshift_reg.sv
// mdiv_pshift_reg: DW-bit register with parallel load and zero-filling right
// shift by WW or by 1; clear beats load, load beats shift.
module mdiv_pshift_reg #(
    parameter int DW = 256,
    parameter int WW = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr_i,
    input  logic          ld_i,
    input  logic          sh_i,
    input  logic          bit_i,
    input  logic [DW-1:0] din_i,
    output logic [DW-1:0] q_o
);
    logic [DW-1:0] q_q, q_d;

    always_comb
        q_d = clr_i ? '0 : ld_i ? din_i : sh_i ? (bit_i ? q_q >> 1 : q_q >> WW) : q_q;

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) q_q <= '0;
        else        q_q <= q_d;

    assign q_o = q_q;
endmodule

// File: rtl/mdiv_result_unloader.sv
// mdiv_result_unloader: captures a DW-bit result and streams it LS word first
// (or LS bit first in bit mode) over a valid/ready port.
module mdiv_result_unloader
    import mdiv_pkg::*;
#(
    parameter int DW = MDIV_DW,
    parameter int WW = MDIV_WW
) (
    input logic                   clk,
    input logic                   rst_n,
    mdiv_result_unloader_if.slave bus_if
);
    localparam int CW = $clog2(DW) + 1;
    localparam logic [CW-1:0] LAST_W = CW'(DW / WW - 1);
    localparam logic [CW-1:0] LAST_B = CW'(DW - 1);

    mdiv_unld_st_e state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          mode_q, mode_d;
    logic          valid_q, last_q;
    logic          take, hs, last;
    logic [DW-1:0] sr_q;

    assign take = (state_q == ST_IDLE) & bus_if.load;
    assign hs   = (state_q == ST_SEND) & bus_if.dout_ready;
    assign last = cnt_q == (mode_q ? LAST_B : LAST_W);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        mode_d  = mode_q;
        if (bus_if.flush) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
        end else if (take) begin
            state_d = ST_SEND;
            cnt_d   = '0;
            mode_d  = bus_if.bit_mode;
        end else if (hs) begin
            state_d = last ? ST_IDLE : ST_SEND;
            cnt_d   = last ? '0 : cnt_q + CW'(1);
        end
    end

    // valid/last are registered from the next state so they line up with sr_q
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            mode_q  <= 1'b0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            mode_q  <= mode_d;
            valid_q <= state_d == ST_SEND;
            last_q  <= (state_d == ST_SEND) && (cnt_d == (mode_d ? LAST_B : LAST_W));
        end

    mdiv_pshift_reg #(.DW(DW), .WW(WW)) u_sr (
        .clk   (clk),
        .rst_n (rst_n),
        .clr_i (bus_if.flush),
        .ld_i  (take),
        .sh_i  (hs),
        .bit_i (mode_q),
        .din_i (bus_if.din),
        .q_o   (sr_q)
    );

    assign bus_if.load_rdy   = ~valid_q;
    assign bus_if.dout_valid = valid_q;
    assign bus_if.dout_last  = last_q;
    assign bus_if.dout       = mode_q ? {{(WW-1){1'b0}}, sr_q[0]} : sr_q[WW-1:0];
endmodule
